// File: rtl/hba_pkg.sv
// Shared HBA master definitions: FSM state encoding, default bus widths and
// the packed command-word width used by the command FIFO.
package hba_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    GRANT_WAIT = 2'd1,
    XFER_WAIT  = 2'd2
  } hba_state_e;

  localparam int HBA_DBUS_WIDTH        = 8;
  localparam int HBA_PERIPH_ADDR_WIDTH = 4;
  localparam int HBA_REG_ADDR_WIDTH    = 8;
  localparam int HBA_FIFO_AW           = 2;

  // Command word layout is {core, reg, data, rnw}.
  function automatic int hba_cmd_width(input int periph_w, input int reg_w, input int dbus_w);
    return periph_w + reg_w + dbus_w + 1;
  endfunction

endpackage

// File: rtl/hba_cmd_fifo.sv
// Synchronous FIFO of 2**AW words with occupancy count; pushes when full and
// pops when empty are ignored. The head word is visible on rdata_o while non-empty.
module hba_cmd_fifo #(
  parameter int WIDTH = 21,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic [AW:0]      count_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // NOTE: storage is deliberately left out of reset; the count and pointers
  // alone define which entries are valid, and a resettable array costs flops.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/hba_master_q.sv
// Queued HBA bus master: commands are buffered in a FIFO and executed in order,
// one response each. Define HBA_MASTER_TIMEOUT_EN to abort stalled transfers.
module hba_master_q
  import hba_pkg::*;
#(
  parameter int DBUS_WIDTH        = HBA_DBUS_WIDTH,
  parameter int PERIPH_ADDR_WIDTH = HBA_PERIPH_ADDR_WIDTH,
  parameter int REG_ADDR_WIDTH    = HBA_REG_ADDR_WIDTH,
  parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
  parameter int FIFO_AW           = HBA_FIFO_AW,
  parameter int TIMEOUT_CYCLES    = 255
) (
  input  logic                         hba_clk,
  input  logic                         hba_reset,
  input  logic                         app_cmd_valid,
  output logic                         app_cmd_ready,
  input  logic [PERIPH_ADDR_WIDTH-1:0] app_cmd_core_addr,
  input  logic [REG_ADDR_WIDTH-1:0]    app_cmd_reg_addr,
  input  logic [DBUS_WIDTH-1:0]        app_cmd_data,
  input  logic                         app_cmd_rnw,
  output logic                         app_rsp_valid,
  output logic [DBUS_WIDTH-1:0]        app_rsp_data,
  output logic                         app_rsp_err,
  output logic [FIFO_AW:0]             app_cmd_count,
  input  logic                         hba_mgrant,
  input  logic                         hba_xferack,
  input  logic [DBUS_WIDTH-1:0]        hba_dbus,
  output logic                         hba_mrequest,
  output logic [ADDR_WIDTH-1:0]        hba_abus_master,
  output logic                         hba_rnw_master,
  output logic                         hba_select_master,
  output logic [DBUS_WIDTH-1:0]        hba_dbus_master
);

  localparam int CMD_W = hba_cmd_width(PERIPH_ADDR_WIDTH, REG_ADDR_WIDTH, DBUS_WIDTH);

  typedef struct packed {
    logic [PERIPH_ADDR_WIDTH-1:0] core;
    logic [REG_ADDR_WIDTH-1:0]    reg_addr;
    logic [DBUS_WIDTH-1:0]        data;
    logic                         rnw;
  } cmd_t;

  cmd_t                  push_cmd, head_cmd, cmd_q;
  hba_state_e            state_q;
  logic                  fifo_full, fifo_empty, pop;
  logic [ADDR_WIDTH-1:0] abus_q;
  logic [DBUS_WIDTH-1:0] dbus_q, rsp_data_q;
  logic                  rnw_q, select_q, rsp_valid_q;

  assign push_cmd = {app_cmd_core_addr, app_cmd_reg_addr, app_cmd_data, app_cmd_rnw};
  assign pop      = (state_q == IDLE) && !fifo_empty;

  hba_cmd_fifo #(
    .WIDTH (CMD_W),
    .AW    (FIFO_AW)
  ) u_cmd_fifo (
    .clk     (hba_clk),
    .rst     (hba_reset),
    .push_i  (app_cmd_valid),
    .wdata_i (push_cmd),
    .pop_i   (pop),
    .rdata_o (head_cmd),
    .count_o (app_cmd_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

`ifdef HBA_MASTER_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             rsp_err_q;
  assign tmo_d = tmo_q + TMO_W'(1);
`endif

  always_ff @(posedge hba_clk) begin
    if (hba_reset) begin
      state_q     <= IDLE;
      cmd_q       <= '0;
      abus_q      <= '0;
      rnw_q       <= 1'b0;
      dbus_q      <= '0;
      select_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef HBA_MASTER_TIMEOUT_EN
      tmo_q       <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            cmd_q   <= head_cmd;
            state_q <= GRANT_WAIT;
          end
        end
        GRANT_WAIT: begin
          if (hba_mgrant) begin
            abus_q   <= {cmd_q.core, cmd_q.reg_addr};
            rnw_q    <= cmd_q.rnw;
            dbus_q   <= cmd_q.rnw ? '0 : cmd_q.data;
            select_q <= 1'b1;
            state_q  <= XFER_WAIT;
`ifdef HBA_MASTER_TIMEOUT_EN
            tmo_q    <= '0;
`endif
          end
        end
        XFER_WAIT: begin
          // An acknowledge always wins over a coincident timeout.
          if (hba_xferack) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cmd_q.rnw ? hba_dbus : '0;
            abus_q      <= '0;
            rnw_q       <= 1'b0;
            dbus_q      <= '0;
            select_q    <= 1'b0;
            state_q     <= IDLE;
`ifdef HBA_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (tmo_d == TMO_W'(TIMEOUT_CYCLES)) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b1;
            abus_q      <= '0;
            rnw_q       <= 1'b0;
            dbus_q      <= '0;
            select_q    <= 1'b0;
            state_q     <= IDLE;
          end else begin
            tmo_q       <= tmo_d;
`endif
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HBA_MASTER_TIMEOUT_EN
  assign app_rsp_err = rsp_err_q;
`else
  assign app_rsp_err = 1'b0;
`endif

  assign app_cmd_ready     = !fifo_full;
  assign app_rsp_valid     = rsp_valid_q;
  assign app_rsp_data      = rsp_data_q;
  assign hba_mrequest      = (state_q == GRANT_WAIT);
  assign hba_abus_master   = abus_q;
  assign hba_rnw_master    = rnw_q;
  assign hba_select_master = select_q;
  assign hba_dbus_master   = dbus_q;

endmodule

// File: tb/tb_hba_master_q.sv
// Self-checking bench for hba_master_q: directed cases plus randomized traffic
// against a transaction-level model of the queue and bus protocol.
module tb_hba_master_q;

  localparam int TMO = 8;

  typedef struct {
    logic [3:0] core;
    logic [7:0] regad;
    logic [7:0] data;
    logic       rnw;
  } cmd_t;

  logic        hba_clk = 1'b0;
  logic        hba_reset;
  logic        app_cmd_valid;
  logic        app_cmd_ready;
  logic [3:0]  app_cmd_core_addr;
  logic [7:0]  app_cmd_reg_addr;
  logic [7:0]  app_cmd_data;
  logic        app_cmd_rnw;
  logic        app_rsp_valid;
  logic [7:0]  app_rsp_data;
  logic        app_rsp_err;
  logic [2:0]  app_cmd_count;
  logic        hba_mgrant;
  logic        hba_xferack;
  logic [7:0]  hba_dbus;
  logic        hba_mrequest;
  logic [11:0] hba_abus_master;
  logic        hba_rnw_master;
  logic        hba_select_master;
  logic [7:0]  hba_dbus_master;

  int n_checks = 0;
  int n_errors = 0;

  always #5 hba_clk = ~hba_clk;

  hba_master_q #(
    .DBUS_WIDTH        (8),
    .PERIPH_ADDR_WIDTH (4),
    .REG_ADDR_WIDTH    (8),
    .ADDR_WIDTH        (12),
    .FIFO_AW           (2),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .hba_clk           (hba_clk),
    .hba_reset         (hba_reset),
    .app_cmd_valid     (app_cmd_valid),
    .app_cmd_ready     (app_cmd_ready),
    .app_cmd_core_addr (app_cmd_core_addr),
    .app_cmd_reg_addr  (app_cmd_reg_addr),
    .app_cmd_data      (app_cmd_data),
    .app_cmd_rnw       (app_cmd_rnw),
    .app_rsp_valid     (app_rsp_valid),
    .app_rsp_data      (app_rsp_data),
    .app_rsp_err       (app_rsp_err),
    .app_cmd_count     (app_cmd_count),
    .hba_mgrant        (hba_mgrant),
    .hba_xferack       (hba_xferack),
    .hba_dbus          (hba_dbus),
    .hba_mrequest      (hba_mrequest),
    .hba_abus_master   (hba_abus_master),
    .hba_rnw_master    (hba_rnw_master),
    .hba_select_master (hba_select_master),
    .hba_dbus_master   (hba_dbus_master)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Bus slave: acknowledges each transfer after a (possibly random) delay and
  // optionally wiggles xferack/dbus while no transfer is in progress.
  bit         slave_en = 1'b1, rand_ack = 1'b0, noise_en = 1'b0, rd_fixed_en = 1'b0;
  logic [7:0] rd_fixed_val = 8'h00;
  int         ack_wait = 0;

  initial begin
    hba_xferack = 1'b0;
    hba_dbus    = 8'h00;
    forever begin
      @(posedge hba_clk); #1;
      if (hba_xferack) begin
        hba_xferack = 1'b0;
        ack_wait    = rand_ack ? $urandom_range(0, 3) : 0;
      end else if (slave_en && hba_select_master) begin
        if (ack_wait == 0) begin
          hba_xferack = 1'b1;
          hba_dbus    = rd_fixed_en ? rd_fixed_val : 8'($urandom);
        end else begin
          ack_wait--;
        end
      end else if (noise_en && !hba_select_master) begin
        hba_xferack = ($urandom_range(0, 4) == 0);
        hba_dbus    = 8'($urandom);
      end
    end
  end

  // Transaction model: expected command order, FIFO occupancy and bus handshake
  // rules, checked every cycle at the falling edge.
  cmd_t       exp_q[$];
  bit         prev_sel, prev_mreq, pend_push, pend_done, pend_err, pend_grant, was_rst;
  bit         last_err;
  logic [7:0] pend_rsp, last_rsp;
  int         fifo_n = 0, sel_age = 0, n_rsp = 0;

  always @(negedge hba_clk) begin
    if (was_rst) begin
      check("reset_outputs",
            {hba_mrequest, hba_select_master, hba_rnw_master, app_rsp_valid, app_rsp_err,
             hba_abus_master, hba_dbus_master, app_rsp_data, app_cmd_count}, 64'd0);
    end else begin
      if (pend_push) fifo_n++;
      if (hba_mrequest && !prev_mreq) fifo_n--;
      check("count", app_cmd_count, fifo_n);
      check("ready", app_cmd_ready, fifo_n < 4);
      check("select", hba_select_master, prev_sel ? !pend_done : pend_grant);
      check("rsp_valid", app_rsp_valid, pend_done);
      if (pend_done) begin
        last_rsp = pend_rsp;
        last_err = pend_err;
        n_rsp++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end
      check("rsp_data", app_rsp_data, last_rsp);
      check("rsp_err", app_rsp_err, last_err);
      check("mreq_and_select", hba_mrequest && hba_select_master, 1'b0);
      if (hba_select_master) begin
        check("bus_has_cmd", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0)
          check("bus_drive", {hba_abus_master, hba_rnw_master, hba_dbus_master},
                {exp_q[0].core, exp_q[0].regad, exp_q[0].rnw,
                 exp_q[0].rnw ? 8'h00 : exp_q[0].data});
      end else begin
        check("bus_idle", {hba_abus_master, hba_rnw_master, hba_dbus_master}, 64'd0);
      end
    end
    sel_age   = hba_select_master ? (prev_sel ? sel_age + 1 : 0) : 0;
    pend_push = app_cmd_valid && app_cmd_ready;
    if (pend_push)
      exp_q.push_back('{app_cmd_core_addr, app_cmd_reg_addr, app_cmd_data, app_cmd_rnw});
    pend_done = hba_select_master && hba_xferack;
    pend_err  = 1'b0;
    pend_rsp  = (pend_done && exp_q.size() != 0 && exp_q[0].rnw) ? hba_dbus : 8'h00;
`ifdef HBA_MASTER_TIMEOUT_EN
    if (hba_select_master && !hba_xferack && sel_age == TMO - 1) begin
      pend_done = 1'b1;
      pend_err  = 1'b1;
      pend_rsp  = 8'h00;
    end
`endif
    pend_grant = hba_mrequest && hba_mgrant;
    prev_sel   = hba_select_master;
    prev_mreq  = hba_mrequest;
    was_rst    = hba_reset;
    if (hba_reset) begin
      exp_q.delete();
      fifo_n     = 0;
      sel_age    = 0;
      pend_push  = 1'b0;
      pend_done  = 1'b0;
      pend_grant = 1'b0;
      prev_sel   = 1'b0;
      prev_mreq  = 1'b0;
      last_rsp   = 8'h00;
      last_err   = 1'b0;
    end
  end

  task automatic push(input logic [3:0] c, input logic [7:0] r, input logic [7:0] d,
                      input logic rnw);
    bit ok = 1'b0;
    app_cmd_core_addr = c;
    app_cmd_reg_addr  = r;
    app_cmd_data      = d;
    app_cmd_rnw       = rnw;
    app_cmd_valid     = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge hba_clk);
      if (app_cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge hba_clk); #1;
    app_cmd_valid = 1'b0;
    check("push_accepted", ok, 1'b1);
  endtask

  task automatic wait_select(input string name);
    for (int i = 0; i < 50; i++) begin
      @(negedge hba_clk);
      if (hba_select_master) break;
    end
    check(name, hba_select_master, 1'b1);
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge hba_clk);
      if (exp_q.size() == 0 && app_cmd_count == 0 && !hba_select_master && !hba_mrequest) begin
        done = 1'b1;
        break;
      end
    end
    check(name, done, 1'b1);
    @(posedge hba_clk); #1;
  endtask

  initial begin
    int  rsp0, pushed, n;
    bit  acc, bad;

    hba_reset         = 1'b1;
    hba_mgrant        = 1'b0;
    app_cmd_valid     = 1'b0;
    app_cmd_core_addr = 4'h0;
    app_cmd_reg_addr  = 8'h00;
    app_cmd_data      = 8'h00;
    app_cmd_rnw       = 1'b0;
    repeat (3) @(posedge hba_clk);
    #1 hba_reset = 1'b0;

    // Single write, grant tied high, ack one cycle after select.
    hba_mgrant = 1'b1;
    push(4'd3, 8'h10, 8'hA5, 1'b0);
    wait_select("wr_select_seen");
    check("wr_abus", hba_abus_master, 12'h310);
    check("wr_dbus_master", hba_dbus_master, 8'hA5);
    check("wr_rnw", hba_rnw_master, 1'b0);
    @(negedge hba_clk);
    check("wr_rsp_valid", app_rsp_valid, 1'b1);
    check("wr_rsp_data", app_rsp_data, 8'h00);
    @(posedge hba_clk); #1;
    wait_drain("wr_drain");

    // Single read returning 0x5C.
    rd_fixed_en  = 1'b1;
    rd_fixed_val = 8'h5C;
    push(4'd1, 8'h02, 8'h77, 1'b1);
    wait_select("rd_select_seen");
    check("rd_abus", hba_abus_master, 12'h102);
    check("rd_dbus_master", hba_dbus_master, 8'h00);
    check("rd_rnw", hba_rnw_master, 1'b1);
    @(negedge hba_clk);
    check("rd_rsp_valid", app_rsp_valid, 1'b1);
    check("rd_rsp_data", app_rsp_data, 8'h5C);
    @(posedge hba_clk); #1;
    wait_drain("rd_drain");
    rd_fixed_en = 1'b0;

    // Fill and backpressure: one command waits for grant, four sit in the FIFO.
    hba_mgrant = 1'b0;
    rsp0 = n_rsp;
    for (int i = 0; i < 5; i++) push(4'(i + 8), 8'(8'h40 + i), 8'(8'hC0 + i), 1'(i % 2));
    @(negedge hba_clk);
    check("fill_count", app_cmd_count, 3'd4);
    check("fill_ready", app_cmd_ready, 1'b0);
    @(posedge hba_clk); #1;
    app_cmd_core_addr = 4'hF;
    app_cmd_reg_addr  = 8'hEE;
    app_cmd_data      = 8'h3C;
    app_cmd_rnw       = 1'b0;
    app_cmd_valid     = 1'b1;
    repeat (3) @(negedge hba_clk);
    check("fill_held_off", app_cmd_ready, 1'b0);
    @(posedge hba_clk); #1;
    hba_mgrant = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge hba_clk);
      if (app_cmd_ready) begin
        acc = 1'b1;
        break;
      end
    end
    @(posedge hba_clk); #1;
    app_cmd_valid = 1'b0;
    check("fill_sixth_accepted", acc, 1'b1);
    wait_drain("fill_drain");
    check("fill_rsp_count", n_rsp - rsp0, 6);

    // Grant delay: request stays up while grant is withheld.
    hba_mgrant = 1'b0;
    push(4'd5, 8'h33, 8'h12, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge hba_clk);
      if (hba_mrequest) break;
    end
    bad = !hba_mrequest;
    repeat (9) begin
      @(negedge hba_clk);
      if (!hba_mrequest || hba_select_master) bad = 1'b1;
    end
    check("gd_mreq_held_10", bad, 1'b0);
    @(posedge hba_clk); #1;
    hba_mgrant = 1'b1;
    @(negedge hba_clk);
    check("gd_select_not_yet", hba_select_master, 1'b0);
    @(negedge hba_clk);
    check("gd_select_after_grant", hba_select_master, 1'b1);
    @(posedge hba_clk); #1;
    wait_drain("gd_drain");

    // Reset mid-transfer with two commands queued.
    slave_en = 1'b0;
    push(4'd2, 8'h20, 8'h01, 1'b0);
    push(4'd2, 8'h21, 8'h02, 1'b1);
    push(4'd2, 8'h22, 8'h03, 1'b0);
    @(negedge hba_clk);
    check("rst_pre_state", {hba_select_master, app_cmd_count}, {1'b1, 3'd2});
    @(posedge hba_clk); #1;
    hba_reset = 1'b1;
    @(posedge hba_clk); #1;
    hba_reset = 1'b0;
    @(negedge hba_clk);
    check("rst_all_clear",
          {hba_select_master, hba_mrequest, app_rsp_valid, app_cmd_count, hba_abus_master},
          64'd0);
    @(posedge hba_clk); #1;
    slave_en = 1'b1;

`ifdef HBA_MASTER_TIMEOUT_EN
    // Timeout: no ack, response flagged exactly TMO cycles after select rises.
    slave_en = 1'b0;
    push(4'd2, 8'h44, 8'h99, 1'b1);
    push(4'd4, 8'h55, 8'h66, 1'b0);
    wait_select("tmo_select_seen");
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge hba_clk);
      n++;
      if (app_rsp_valid) break;
    end
    check("tmo_latency", n, TMO);
    check("tmo_rsp_err", app_rsp_err, 1'b1);
    check("tmo_rsp_data", app_rsp_data, 8'h00);
    @(posedge hba_clk); #1;
    slave_en = 1'b1;
    wait_drain("tmo_drain");
    check("tmo_next_ok", app_rsp_err, 1'b0);
`endif

    // Randomized traffic: random grant, ack delay, bus noise and push gaps.
    rand_ack = 1'b1;
    noise_en = 1'b1;
    pushed   = 0;
    for (int c = 0; c < 2000 && pushed < 40; c++) begin
      @(negedge hba_clk);
      acc = app_cmd_valid && app_cmd_ready;
      @(posedge hba_clk); #1;
      if (acc) begin
        pushed++;
        app_cmd_valid = 1'b0;
      end
      if (!app_cmd_valid && pushed < 40 && $urandom_range(0, 2) == 0) begin
        app_cmd_core_addr = 4'($urandom);
        app_cmd_reg_addr  = 8'($urandom);
        app_cmd_data      = 8'($urandom);
        app_cmd_rnw       = 1'($urandom);
        app_cmd_valid     = 1'b1;
      end
      hba_mgrant = ($urandom_range(0, 3) != 0);
    end
    app_cmd_valid = 1'b0;
    hba_mgrant    = 1'b1;
    check("rand_all_pushed", pushed, 40);
    wait_drain("rand_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
